// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants and types for the serializer slice.
package tmds_pkg;

  localparam int unsigned SYM_W_DEF = 10;

  typedef logic [SYM_W_DEF-1:0] sym_t;

  // Five ones then five zeros: one pixel-clock period per symbol time
  localparam sym_t TMDS_CLK_PATTERN = 10'b0000011111;

  localparam sym_t TMDS_CTRL_00 = 10'b1101010100;
  localparam sym_t TMDS_CTRL_01 = 10'b0010101011;
  localparam sym_t TMDS_CTRL_10 = 10'b0101010100;
  localparam sym_t TMDS_CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/tmds_lane_shift.sv
// One serializer lane: symbol shift register, polarity swap and output register.
module tmds_lane_shift
  import tmds_pkg::*;
#(
  parameter int unsigned SYM_W   = SYM_W_DEF,
  parameter int unsigned OUT_W   = 2,
  parameter logic [SYM_W-1:0] RST_SYM = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             load,
  input  logic [SYM_W-1:0] load_sym,
  input  logic             invert,
  output logic [OUT_W-1:0] out_p
);

  logic [SYM_W-1:0] shift;

  // Shift out OUT_W bits per clock, reload on the boundary, freeze on slip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= RST_SYM;
    end else if (advance) begin
      if (load) begin
        shift <= load_sym;
      end else begin
        shift <= shift >> OUT_W;
      end
    end
  end

  // Register the low bits with optional polarity swap; repeat during slip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p <= '0;
    end else if (advance) begin
      out_p <= shift[OUT_W-1:0] ^ {OUT_W{invert}};
    end
  end

endmodule

// File: rtl/tmds_serializer.sv
// Multi-lane TMDS serializer: beat counter, one-entry holding buffer,
// handshake, underrun tracking and per-lane shift registers.
module tmds_serializer
  import tmds_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned SYM_W       = SYM_W_DEF,
  parameter int unsigned OUT_W       = 2,
  parameter bit          CLK_LANE_EN = 1'b1,
  parameter logic [SYM_W-1:0] IDLE_SYM = SYM_W'(TMDS_CTRL_00)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*SYM_W-1:0] sym_data,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic                   slip,
  input  logic [LANES-1:0]       invert,
  output logic                   underrun,
  input  logic                   underrun_clr,
  output logic [LANES*OUT_W-1:0] out_p,
  output logic [LANES*OUT_W-1:0] out_n
);

  localparam int unsigned BEATS = SYM_W / OUT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [SYM_W-1:0] CLK_SYM = SYM_W'(TMDS_CLK_PATTERN);

  logic [CNT_W-1:0]       cnt;
  logic                   hold_full;
  logic [LANES*SYM_W-1:0] hold;
  logic                   do_load;
  logic                   xfer;
  logic                   use_idle;

  assign sym_ready = ~hold_full;
  assign xfer      = sym_valid & ~hold_full;
  assign do_load   = (cnt == LAST_BEAT) & ~slip;
  assign use_idle  = ~hold_full & ~sym_valid;

  // Beat counter; a slip freezes it so the boundary moves one clock later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!slip) begin
      cnt <= (cnt == LAST_BEAT) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Holding buffer: drained on every load beat, filled by off-boundary transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else if (do_load) begin
      hold_full <= 1'b0;
    end else if (xfer) begin
      hold_full <= 1'b1;
      hold      <= sym_data;
    end
  end

  // Sticky underrun; clear beats a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end else if (do_load && use_idle) begin
      underrun <= 1'b1;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam bit IS_CLK = CLK_LANE_EN && (l == LANES - 1);
    localparam logic [SYM_W-1:0] RST_SYM = IS_CLK ? CLK_SYM : IDLE_SYM;

    logic [SYM_W-1:0] lane_sym;

    if (IS_CLK) begin : g_clk
      assign lane_sym = CLK_SYM;
    end else begin : g_data
      // Load source priority: held symbol, then bypass, then idle token
      always_comb begin
        lane_sym = IDLE_SYM;
        if (hold_full) begin
          lane_sym = hold[l*SYM_W +: SYM_W];
        end else if (sym_valid) begin
          lane_sym = sym_data[l*SYM_W +: SYM_W];
        end
      end
    end

    tmds_lane_shift #(
      .SYM_W   (SYM_W),
      .OUT_W   (OUT_W),
      .RST_SYM (RST_SYM)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (~slip),
      .load     (do_load),
      .load_sym (lane_sym),
      .invert   (invert[l]),
      .out_p    (out_p[l*OUT_W +: OUT_W])
    );
  end

  assign out_n = ~out_p;

endmodule

// File: tb/tb_tmds_serializer.sv
// Directed bench for tmds_serializer (4 lanes, 10-bit symbols, 2 bits/clock).
module tb_tmds_serializer;
  import tmds_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned SYM_W = 10;
  localparam int unsigned OUT_W = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [LANES*SYM_W-1:0] sym_data;
  logic                   sym_valid;
  logic                   sym_ready;
  logic                   slip;
  logic [LANES-1:0]       invert;
  logic                   underrun;
  logic                   underrun_clr;
  logic [LANES*OUT_W-1:0] out_p;
  logic [LANES*OUT_W-1:0] out_n;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Edges 1..10 after reset with lane data 2AA/155/3F0 and clock lane 3
  logic [7:0] exp_a   [10] = '{8'hC0, 8'hD5, 8'h55, 8'h15, 8'h3F,
                               8'hC6, 8'hC6, 8'h76, 8'h36, 8'h36};
  logic       exp_rdy [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  // One idle symbol on lanes 0-2 in phase with the clock lane
  logic [7:0] exp_idle [5] = '{8'hC0, 8'hD5, 8'h55, 8'h15, 8'h3F};
  // Lane 0 pairs for edges 6..22, slips on edges 8 and 16 (symbol 10'h0E4)
  logic [1:0] exp_slip [17] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00,
                                2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00,
                                2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

  tmds_serializer #(
    .LANES       (LANES),
    .SYM_W       (SYM_W),
    .OUT_W       (OUT_W),
    .CLK_LANE_EN (1'b1),
    .IDLE_SYM    (TMDS_CTRL_00)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sym_data     (sym_data),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .slip         (slip),
    .invert       (invert),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .out_p        (out_p),
    .out_n        (out_n)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  logic [7:0] e8;
  logic [9:0] acc;
  logic [9:0] d;
  logic       xfer;

  initial begin
    rst_n = 1'b0; sym_valid = 1'b0; sym_data = '0; slip = 1'b0;
    invert = '0; underrun_clr = 1'b0;
    #2;
    check_vec("rst_out_p", 32'(out_p), 32'h00);
    check_vec("rst_out_n", 32'(out_n), 32'hFF);
    check_vec("rst_ready", 32'(sym_ready), 32'h1);
    check_vec("rst_underrun", 32'(underrun), 32'h0);

    // Steady stream: idle symbol first, then the data symbol
    apply_reset();
    sym_valid = 1'b1;
    sym_data  = {10'h3FF, 10'h3F0, 10'h155, 10'h2AA};
    for (int i = 0; i < 10; i++) begin
      tick();
      e8 = ~exp_a[i];
      check_vec("stream_out_p", 32'(out_p), 32'(exp_a[i]));
      check_vec("stream_out_n", 32'(out_n), 32'(e8));
      check_vec("stream_ready", 32'(sym_ready), 32'(exp_rdy[i]));
    end
    check_vec("stream_underrun", 32'(underrun), 32'h0);

    // Bypass on a load beat, then underrun with idle insertion and clears
    sym_valid = 1'b0;
    apply_reset();
    repeat (4) tick();
    sym_valid = 1'b1;
    sym_data  = {10'h000, 10'h000, 10'h000, 10'h1C7};
    tick();
    sym_valid = 1'b0;
    check_vec("bypass_ready", 32'(sym_ready), 32'h1);
    check_vec("bypass_underrun", 32'(underrun), 32'h0);
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc = {out_p[1:0], acc[9:2]};
      if (i == 3) check_vec("pre_underrun", 32'(underrun), 32'h0);
    end
    check_vec("bypass_symbol", 32'(acc), 32'h1C7);
    check_vec("underrun_set", 32'(underrun), 32'h1);
    for (int i = 0; i < 5; i++) begin
      underrun_clr = (i == 1);
      tick();
      underrun_clr = 1'b0;
      check_vec("idle_out_p", 32'(out_p), 32'(exp_idle[i]));
      if (i == 1) check_vec("underrun_clr", 32'(underrun), 32'h0);
      if (i == 4) check_vec("underrun_reset", 32'(underrun), 32'h1);
    end
    repeat (4) tick();
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check_vec("clr_beats_set", 32'(underrun), 32'h0);
    repeat (5) tick();
    check_vec("underrun_again", 32'(underrun), 32'h1);

    // Back-to-back transfers with incrementing lane 0 data
    d = 10'd1;
    sym_data = '0;
    sym_data[9:0] = d;
    apply_reset();
    sym_valid = 1'b1;
    acc = '0;
    for (int n = 1; n <= 20; n++) begin
      xfer = sym_valid && sym_ready;
      tick();
      if (xfer) d = d + 10'd1;
      sym_data[9:0] = d;
      if (cyc >= 6) acc = {out_p[1:0], acc[9:2]};
      if (cyc == 10) check_vec("b2b_ready_free", 32'(sym_ready), 32'h1);
      if (cyc == 11) check_vec("b2b_ready_full", 32'(sym_ready), 32'h0);
      if (cyc >= 10 && (cyc % 5) == 0)
        check_vec("b2b_symbol", 32'(acc), 32'(cyc / 5 - 1));
    end
    check_vec("b2b_underrun", 32'(underrun), 32'h0);

    // Slip mid-symbol (cnt=2) and on the load beat
    sym_data = {10'h000, 10'h000, 10'h000, 10'h0E4};
    apply_reset();
    repeat (5) tick();
    for (int i = 0; i < 17; i++) begin
      slip = (i == 2) || (i == 10);
      tick();
      slip = 1'b0;
      check_vec("slip_lane0", 32'(out_p[1:0]), 32'(exp_slip[i]));
    end

    // Polarity swap on lanes 0 and 2
    invert   = 4'b0101;
    sym_data = {10'h3FF, 10'h3F0, 10'h155, 10'h2AA};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      e8 = exp_a[i] ^ 8'h33;
      check_vec("inv_out_p", 32'(out_p), 32'(e8));
      e8 = ~e8;
      check_vec("inv_out_n", 32'(out_n), 32'(e8));
    end

    // Asynchronous reset mid-symbol with the holding buffer full
    repeat (3) tick();
    check_vec("pre_rst_hold_full", 32'(sym_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_out_p", 32'(out_p), 32'h00);
    check_vec("async_out_n", 32'(out_n), 32'hFF);
    check_vec("async_ready", 32'(sym_ready), 32'h1);
    invert    = '0;
    sym_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec("restart_idle", 32'(out_p), 32'(exp_idle[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
